ase_pcie_ss_tx_arbiter: RTL and testbench
=========================================

Name: ase_pcie_ss_tx_arbiter

Overview:
Packet-atomic round-robin arbiter that merges NUM_SRC AFU->host AXI-S TLP streams onto the single PCIe SS TX stream consumed by the ASE PCIe SS emulator.
- Sits between multiple AFU-side TX sources (e.g. DMA engine, MMIO completion path, interrupt generator) and the emulator's TX sink.
- A granted source keeps the grant until its tlast beat is accepted, so TLPs never interleave.
- Output is registered through a skid buffer, so in_tready never depends combinationally on out_tready.

Parameters:
- NUM_SRC, 4, number of requesters (1..16).
- TDATA_WIDTH, 512, tdata width in bits.
- TUSER_WIDTH, 10, tuser_vendor width in bits.
- TKEEP_WIDTH, TDATA_WIDTH/8, tkeep width in bits.
- SRC_IDX_W, $clog2(NUM_SRC) (minimum 1), grant index width.

Ports:
- clk  in  1  stream clock; all logic on posedge.
- SoftReset  in  1  asynchronous, active-high reset.
- in_tvalid  in  NUM_SRC  per-source valid.
- in_tready  out  NUM_SRC  per-source ready.
- in_tlast  in  NUM_SRC  per-source end of packet.
- in_tdata  in  NUM_SRC x TDATA_WIDTH  per-source data.
- in_tuser  in  NUM_SRC x TUSER_WIDTH  per-source tuser_vendor.
- in_tkeep  in  NUM_SRC x TKEEP_WIDTH  per-source byte enables.
- out_tvalid  out  1  merged valid.
- out_tready  in  1  sink ready.
- out_tlast  out  1  merged end of packet.
- out_tdata  out  TDATA_WIDTH  merged data.
- out_tuser  out  TUSER_WIDTH  merged tuser_vendor.
- out_tkeep  out  TKEEP_WIDTH  merged byte enables.
- cur_grant  out  SRC_IDX_W  index of the source currently granted or locked.
- locked  out  1  high while a packet is in progress (state LOCKED).
- pkt_count  out  32  total packets forwarded (counted on out tlast handshake); wraps at 2^32.

Behaviour:
- Reset (async assert, sync release):
  - out_tvalid=0, in_tready=0, locked=0, cur_grant=0, pkt_count=0.
  - Round-robin pointer rr_ptr=0; skid buffer empty; out_tlast/tdata/tuser/tkeep=0.
- Acceptance: a beat on source i is accepted when in_tvalid[i] && in_tready[i]. in_tready[i] = (grant==i) && skid_has_space, where skid_has_space means fewer than 2 entries held. At most one in_tready bit is high per cycle.
- States:
  - IDLE: the winner is the first i with in_tvalid[i], searching from rr_ptr upward with wrap N-1->0. grant=winner, combinational. If no source is valid, in_tready=0.
    - Winner beat accepted with tlast=1: stay IDLE; rr_ptr=winner+1 mod NUM_SRC.
    - Winner beat accepted with tlast=0: go to LOCKED; latch lock_idx=winner.
  - LOCKED: grant=lock_idx regardless of other valids. A tvalid bubble on the locked source holds the lock. Accepting tlast returns to IDLE with rr_ptr=lock_idx+1 mod NUM_SRC.
- Throughput and latency:
  - One beat per cycle sustained, including single-beat packets from different sources on consecutive cycles.
  - Latency: an accepted input beat appears on out_* the next cycle.
- Output rules:
  - out_* hold stable while out_tvalid && !out_tready.
  - The skid buffer absorbs one in-flight beat when out_tready drops.
- cur_grant: shows lock_idx in LOCKED, the IDLE winner otherwise; holds its last value when no source is valid.
- Corner cases:
  - NUM_SRC=1: passthrough plus register stage.
  - in_tvalid dropped by a non-granted source: no effect.
  - Reset asserted mid-packet: partial packet and skid contents are discarded; return to IDLE.

Optional Feature:
- ASE_PCIE_SS_TX_ARB_SRC0_PRIORITY_EN.
- Defined: in IDLE, source 0 wins whenever in_tvalid[0]=1, independent of rr_ptr. This is intended for MMIO read completions. An in-progress packet from another source is never preempted. rr_ptr updates only when a non-zero source completes a packet.
- Undefined: pure round-robin as above.

Decomposition:
- Package ase_pcie_ss_tx_arb_pkg: t_arb_state enum (IDLE, LOCKED) and the rr next-index function (find-first-set from pointer, with wrap).
- Sub-module ase_pcie_ss_axis_skid: 2-entry AXI-S register slice over {tlast, tuser, tkeep, tdata}. It exports has_space, and the arbiter instantiates it once.

Test Plan:
- Reset release with all sources idle -> out_tvalid=0, in_tready=0 for 10 cycles, pkt_count=0.
- Sources 0..3 each present one 1-beat packet every cycle with out_tready=1 -> output order 0,1,2,3,0,... with one beat/cycle, pkt_count +4 per 4 cycles.
- Source 1 sends a 4-beat packet with a 2-cycle tvalid bubble after beat 2 while source 2 is valid -> no source-2 beat appears until source-1 tlast; then source 2 is granted.
- out_tready toggles 1,0,0,1 during a 3-beat packet -> no beat lost or duplicated, out_* stable while stalled, in_tready deasserts once the skid holds 2 beats.
- SoftReset asserted after beat 2 of a 5-beat packet -> out_tvalid=0 immediately; after release, a new packet from source 3 is granted first with rr_ptr=0 search order.
- With ASE_PCIE_SS_TX_ARB_SRC0_PRIORITY_EN, sources 0 and 2 continuously valid with 1-beat packets -> source 0 wins every IDLE cycle. Source 0 raised mid-way through a source-2 multi-beat packet waits for that packet's tlast.

Source files
------------

// File: rtl/ase_pcie_ss_tx_arb_pkg.sv
// rtl/ase_pcie_ss_tx_arb_pkg.sv - arbiter state type and round-robin search helper
package ase_pcie_ss_tx_arb_pkg;

    localparam int MAX_SRC   = 16;
    localparam int MAX_IDX_W = 4;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } t_arb_state;

    // First requester at or above ptr, wrapping from num_src-1 back to 0.
    function automatic logic [MAX_IDX_W-1:0] rr_next_idx(
        input logic [MAX_SRC-1:0]   req,
        input logic [MAX_IDX_W-1:0] ptr,
        input int                   num_src
    );
        logic [MAX_IDX_W-1:0] idx;
        logic                 found;
        int                   cand;
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < MAX_SRC; i++) begin
            if (i < num_src) begin
                cand = int'(ptr) + i;
                if (cand >= num_src) begin
                    cand = cand - num_src;
                end
                if (!found && req[cand]) begin
                    found = 1'b1;
                    idx   = MAX_IDX_W'(cand);
                end
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/ase_pcie_ss_axis_skid.sv
// rtl/ase_pcie_ss_axis_skid.sv - two-entry AXI-S register slice; has_space is purely registered
module ase_pcie_ss_axis_skid #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_tvalid,
    input  logic [WIDTH-1:0] in_tdata,
    output logic             has_space,
    output logic             out_tvalid,
    input  logic             out_tready,
    output logic [WIDTH-1:0] out_tdata
);

    logic [1:0]       count_q, count_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic [WIDTH-1:0] spare_q, spare_d;
    logic             push, pop;

    assign has_space  = (count_q != 2'd2);
    assign out_tvalid = (count_q != 2'd0);
    assign out_tdata  = head_q;
    assign push       = in_tvalid && has_space;
    assign pop        = out_tvalid && out_tready;

    // head_q only moves on a pop or when empty, so the output holds while stalled
    always_comb begin
        count_d = count_q;
        head_d  = head_q;
        spare_d = spare_q;
        case ({push, pop})
            2'b10: begin
                if (count_q == 2'd0) begin
                    head_d = in_tdata;
                end else begin
                    spare_d = in_tdata;
                end
                count_d = count_q + 2'd1;
            end
            2'b01: begin
                if (count_q == 2'd2) begin
                    head_d = spare_q;
                end
                count_d = count_q - 2'd1;
            end
            2'b11: begin
                head_d = in_tdata;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= 2'd0;
            head_q  <= '0;
            spare_q <= '0;
        end else begin
            count_q <= count_d;
            head_q  <= head_d;
            spare_q <= spare_d;
        end
    end

endmodule

// File: rtl/ase_pcie_ss_tx_arbiter.sv
// rtl/ase_pcie_ss_tx_arbiter.sv - packet-atomic round-robin merge of AFU TX streams (option: ASE_PCIE_SS_TX_ARB_SRC0_PRIORITY_EN)
module ase_pcie_ss_tx_arbiter
    import ase_pcie_ss_tx_arb_pkg::*;
#(
    parameter int NUM_SRC     = 4,
    parameter int TDATA_WIDTH = 512,
    parameter int TUSER_WIDTH = 10,
    parameter int TKEEP_WIDTH = TDATA_WIDTH / 8,
    parameter int SRC_IDX_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic                           clk,
    input  logic                           SoftReset,
    input  logic [NUM_SRC-1:0]             in_tvalid,
    output logic [NUM_SRC-1:0]             in_tready,
    input  logic [NUM_SRC-1:0]             in_tlast,
    input  logic [NUM_SRC*TDATA_WIDTH-1:0] in_tdata,
    input  logic [NUM_SRC*TUSER_WIDTH-1:0] in_tuser,
    input  logic [NUM_SRC*TKEEP_WIDTH-1:0] in_tkeep,
    output logic                           out_tvalid,
    input  logic                           out_tready,
    output logic                           out_tlast,
    output logic [TDATA_WIDTH-1:0]         out_tdata,
    output logic [TUSER_WIDTH-1:0]         out_tuser,
    output logic [TKEEP_WIDTH-1:0]         out_tkeep,
    output logic [SRC_IDX_W-1:0]           cur_grant,
    output logic                           locked,
    output logic [31:0]                    pkt_count
);

    localparam int SKID_W = 1 + TUSER_WIDTH + TKEEP_WIDTH + TDATA_WIDTH;

    t_arb_state           state_q, state_d;
    logic [SRC_IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [SRC_IDX_W-1:0] lock_idx_q, lock_idx_d;
    logic [SRC_IDX_W-1:0] cur_grant_q, cur_grant_d;
    logic [31:0]          pkt_count_q, pkt_count_d;

    logic [MAX_SRC-1:0]   req_ext;
    logic [SRC_IDX_W-1:0] winner, grant, next_ptr;
    logic                 grant_active, has_space, beat_acc, beat_last, ptr_upd;
    int unsigned          gi;
    logic [SKID_W-1:0]    beat_bus, out_bus;

    always_comb begin
        req_ext              = '0;
        req_ext[NUM_SRC-1:0] = in_tvalid;
        winner               = SRC_IDX_W'(rr_next_idx(req_ext, MAX_IDX_W'(rr_ptr_q), NUM_SRC));
`ifdef ASE_PCIE_SS_TX_ARB_SRC0_PRIORITY_EN
        if (in_tvalid[0]) begin
            winner = '0;
        end
`endif
    end

    // With nothing valid in IDLE the grant index parks on its last value
    always_comb begin
        if (state_q == LOCKED) begin
            grant        = lock_idx_q;
            grant_active = 1'b1;
        end else if (|in_tvalid) begin
            grant        = winner;
            grant_active = 1'b1;
        end else begin
            grant        = cur_grant_q;
            grant_active = 1'b0;
        end
    end

    always_comb begin
        in_tready = '0;
        if (grant_active && has_space && !SoftReset) begin
            in_tready[grant] = 1'b1;
        end
    end

    always_comb begin
        gi        = 32'(grant);
        beat_acc  = in_tvalid[grant] && in_tready[grant];
        beat_last = in_tlast[grant];
        beat_bus  = {in_tlast[grant],
                     in_tuser[gi*TUSER_WIDTH +: TUSER_WIDTH],
                     in_tkeep[gi*TKEEP_WIDTH +: TKEEP_WIDTH],
                     in_tdata[gi*TDATA_WIDTH +: TDATA_WIDTH]};
        next_ptr  = (grant == SRC_IDX_W'(NUM_SRC - 1)) ? '0 : grant + SRC_IDX_W'(1);
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        lock_idx_d  = lock_idx_q;
        cur_grant_d = grant;
        pkt_count_d = pkt_count_q + ((out_tvalid && out_tready && out_tlast) ? 32'd1 : 32'd0);
        ptr_upd     = 1'b0;
        case (state_q)
            IDLE: begin
                if (beat_acc) begin
                    if (beat_last) begin
                        ptr_upd = 1'b1;
                    end else begin
                        state_d    = LOCKED;
                        lock_idx_d = grant;
                    end
                end
            end
            LOCKED: begin
                if (beat_acc && beat_last) begin
                    state_d = IDLE;
                    ptr_upd = 1'b1;
                end
            end
        endcase
`ifdef ASE_PCIE_SS_TX_ARB_SRC0_PRIORITY_EN
        // Source 0 bypasses the rotation, so its packets must not advance it
        if (grant == '0) begin
            ptr_upd = 1'b0;
        end
`endif
        if (ptr_upd) begin
            rr_ptr_d = next_ptr;
        end
    end

    always_ff @(posedge clk or posedge SoftReset) begin
        if (SoftReset) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            lock_idx_q  <= '0;
            cur_grant_q <= '0;
            pkt_count_q <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            lock_idx_q  <= lock_idx_d;
            cur_grant_q <= cur_grant_d;
            pkt_count_q <= pkt_count_d;
        end
    end

    ase_pcie_ss_axis_skid #(
        .WIDTH(SKID_W)
    ) u_skid (
        .clk       (clk),
        .rst       (SoftReset),
        .in_tvalid (grant_active && in_tvalid[grant]),
        .in_tdata  (beat_bus),
        .has_space (has_space),
        .out_tvalid(out_tvalid),
        .out_tready(out_tready),
        .out_tdata (out_bus)
    );

    assign {out_tlast, out_tuser, out_tkeep, out_tdata} = out_bus;
    assign cur_grant = grant;
    assign locked    = (state_q == LOCKED);
    assign pkt_count = pkt_count_q;

endmodule

// File: tb/tb_ase_pcie_ss_tx_arbiter.sv
// tb/tb_ase_pcie_ss_tx_arbiter.sv - scoreboard bench for ase_pcie_ss_tx_arbiter
`timescale 1ns/1ps
module tb_ase_pcie_ss_tx_arbiter;

    localparam int NS = 4;
    localparam int DW = 64;
    localparam int UW = 10;
    localparam int KW = 8;
    localparam int IW = 2;
    localparam int BW = 1 + UW + KW + DW;

    typedef struct packed {
        logic [BW-1:0] bus;
        logic [7:0]    gap;
    } beat_t;

    logic             clk = 1'b0;
    logic             SoftReset;
    logic [NS-1:0]    in_tvalid, in_tready, in_tlast;
    logic [NS*DW-1:0] in_tdata;
    logic [NS*UW-1:0] in_tuser;
    logic [NS*KW-1:0] in_tkeep;
    logic             out_tvalid, out_tready, out_tlast;
    logic [DW-1:0]    out_tdata;
    logic [UW-1:0]    out_tuser;
    logic [KW-1:0]    out_tkeep;
    logic [IW-1:0]    cur_grant;
    logic             locked;
    logic [31:0]      pkt_count;
    logic [BW-1:0]    out_bus;

    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    int            first_cyc = -1;
    int            last_cyc = -1;
    beat_t         src_q[NS][$];
    logic [BW-1:0] exp_q[$];

    always #5 clk = ~clk;

    assign out_bus = {out_tlast, out_tuser, out_tkeep, out_tdata};

    ase_pcie_ss_tx_arbiter #(
        .NUM_SRC(NS), .TDATA_WIDTH(DW), .TUSER_WIDTH(UW), .TKEEP_WIDTH(KW), .SRC_IDX_W(IW)
    ) dut (
        .clk(clk), .SoftReset(SoftReset),
        .in_tvalid(in_tvalid), .in_tready(in_tready), .in_tlast(in_tlast),
        .in_tdata(in_tdata), .in_tuser(in_tuser), .in_tkeep(in_tkeep),
        .out_tvalid(out_tvalid), .out_tready(out_tready), .out_tlast(out_tlast),
        .out_tdata(out_tdata), .out_tuser(out_tuser), .out_tkeep(out_tkeep),
        .cur_grant(cur_grant), .locked(locked), .pkt_count(pkt_count)
    );

    function automatic logic [BW-1:0] mk_beat(int src, int pkt, int beat, logic last);
        logic [DW-1:0] d;
        logic [UW-1:0] u;
        logic [KW-1:0] k;
        d = {8'(src), 8'(pkt), 8'(beat), 40'h5A_C3E1_0F96};
        u = 10'(src * 37 + beat * 5 + pkt);
        k = last ? 8'h0F : 8'hFF;
        return {last, u, k, d};
    endfunction

    task automatic check(string tag, logic [127:0] obs, logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_pkt(int src, int pkt, int nb, int gap_at, int gap);
        beat_t b;
        for (int k = 0; k < nb; k++) begin
            b.bus = mk_beat(src, pkt, k, (k == nb - 1));
            b.gap = (k == gap_at) ? 8'(gap) : 8'd0;
            src_q[src].push_back(b);
        end
    endtask

    task automatic expect_pkt(int src, int pkt, int nb);
        for (int k = 0; k < nb; k++) begin
            exp_q.push_back(mk_beat(src, pkt, k, (k == nb - 1)));
        end
    endtask

    task automatic step(int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic wait_drain(string tag, int maxc);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < maxc) begin
            step();
            k++;
        end
        check(tag, 128'(exp_q.size()), 128'(0));
        step();
    endtask

    // Source model: presents queue heads, honours per-beat pre-gaps, pops on handshake
    initial begin
        logic [NS-1:0] acc;
        beat_t         h;
        in_tvalid = '0;
        in_tlast  = '0;
        in_tdata  = '0;
        in_tuser  = '0;
        in_tkeep  = '0;
        forever begin
            @(negedge clk);
            acc = in_tvalid & in_tready;
            @(posedge clk);
            #1;
            for (int i = 0; i < NS; i++) begin
                if (acc[i] && src_q[i].size() > 0) begin
                    void'(src_q[i].pop_front());
                end
                in_tvalid[i]            = 1'b0;
                in_tlast[i]             = 1'b0;
                in_tdata[i*DW +: DW]    = '0;
                in_tuser[i*UW +: UW]    = '0;
                in_tkeep[i*KW +: KW]    = '0;
                if (src_q[i].size() > 0) begin
                    h = src_q[i][0];
                    if (h.gap != 8'd0) begin
                        h.gap       = h.gap - 8'd1;
                        src_q[i][0] = h;
                    end else begin
                        in_tvalid[i] = 1'b1;
                        {in_tlast[i], in_tuser[i*UW +: UW], in_tkeep[i*KW +: KW],
                         in_tdata[i*DW +: DW]} = h.bus;
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (out_tvalid === 1'b1 && out_tready === 1'b1) begin
                if (first_cyc < 0) first_cyc = cyc;
                last_cyc = cyc;
                if (exp_q.size() == 0) begin
                    check("extra_out_beat", 128'(exp_q.size()), 128'(1));
                end else begin
                    check("out_beat", 128'(out_bus), 128'(exp_q.pop_front()));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int ord2_src[8];
        int ord2_pkt[8];
        int ord6_src[6];
        int ord6_pkt[6];
        int k;
`ifdef ASE_PCIE_SS_TX_ARB_SRC0_PRIORITY_EN
        ord2_src = '{0, 0, 1, 2, 3, 1, 2, 3};
        ord2_pkt = '{0, 1, 0, 0, 0, 1, 1, 1};
        ord6_src = '{0, 0, 0, 2, 2, 2};
        ord6_pkt = '{6, 7, 8, 6, 7, 8};
`else
        ord2_src = '{0, 1, 2, 3, 0, 1, 2, 3};
        ord2_pkt = '{0, 0, 0, 0, 1, 1, 1, 1};
        ord6_src = '{0, 2, 0, 2, 0, 2};
        ord6_pkt = '{6, 6, 7, 7, 8, 8};
`endif
        SoftReset  = 1'b1;
        out_tready = 1'b0;
        step(3);
        SoftReset = 1'b0;

        // idle after reset
        for (int i = 0; i < 10; i++) begin
            step();
            check("idle_out_tvalid", 128'(out_tvalid), 128'(0));
            check("idle_in_tready", 128'(in_tready), 128'(0));
        end
        check("reset_pkt_count", 128'(pkt_count), 128'(0));
        check("reset_locked", 128'(locked), 128'(0));
        check("reset_cur_grant", 128'(cur_grant), 128'(0));
        check("reset_out_tdata", 128'(out_tdata), 128'(0));

        // back-to-back single-beat packets from all sources
        out_tready = 1'b1;
        for (int p = 0; p < 2; p++)
            for (int s = 0; s < NS; s++) send_pkt(s, p, 1, -1, 0);
        for (int i = 0; i < 8; i++) expect_pkt(ord2_src[i], ord2_pkt[i], 1);
        first_cyc = -1;
        wait_drain("rr_drain", 40);
        check("rr_back_to_back", 128'(last_cyc - first_cyc), 128'(7));
        check("rr_pkt_count", 128'(pkt_count), 128'(8));

        // source 1 with a 2-cycle bubble holds the lock against source 2
        send_pkt(1, 2, 4, 2, 2);
        send_pkt(2, 2, 2, -1, 0);
        expect_pkt(1, 2, 4);
        expect_pkt(2, 2, 2);
        step(4);
        check("bubble_locked", 128'(locked), 128'(1));
        check("bubble_cur_grant", 128'(cur_grant), 128'(1));
        check("bubble_in_tready", 128'(in_tready), 128'(4'b0010));
        wait_drain("bubble_drain", 40);
        check("bubble_pkt_count", 128'(pkt_count), 128'(10));

        // out_tready 1,0,0,1 during a 3-beat packet with source 1 waiting
        send_pkt(0, 3, 3, -1, 0);
        send_pkt(1, 3, 1, -1, 0);
        expect_pkt(0, 3, 3);
        expect_pkt(1, 3, 1);
        step(3);
        out_tready = 1'b0;
        step();
        check("stall_out_a", 128'(out_bus), 128'(mk_beat(0, 3, 1, 1'b0)));
        check("stall_valid_a", 128'(out_tvalid), 128'(1));
        check("stall_in_tready_a", 128'(in_tready), 128'(0));
        step();
        check("stall_out_b", 128'(out_bus), 128'(mk_beat(0, 3, 1, 1'b0)));
        check("stall_in_tready_b", 128'(in_tready), 128'(0));
        out_tready = 1'b1;
        wait_drain("stall_drain", 40);
        check("stall_pkt_count", 128'(pkt_count), 128'(12));

        // reset in the middle of a 5-beat packet
        send_pkt(1, 4, 5, -1, 0);
        expect_pkt(1, 4, 5);
        k = 0;
        while (exp_q.size() > 3 && k < 20) begin
            step();
            k++;
        end
        check("midpkt_two_beats_out", 128'(exp_q.size()), 128'(3));
        SoftReset = 1'b1;
        #1;
        check("midrst_out_tvalid", 128'(out_tvalid), 128'(0));
        check("midrst_in_tready", 128'(in_tready), 128'(0));
        check("midrst_locked", 128'(locked), 128'(0));
        check("midrst_pkt_count", 128'(pkt_count), 128'(0));
        check("midrst_out_tdata", 128'(out_tdata), 128'(0));
        src_q[1].delete();
        exp_q.delete();
        step(2);
        SoftReset = 1'b0;
        send_pkt(3, 5, 2, -1, 0);
        expect_pkt(3, 5, 2);
        step();
        check("postrst_cur_grant", 128'(cur_grant), 128'(3));
        check("postrst_in_tready", 128'(in_tready), 128'(4'b1000));
        wait_drain("postrst_drain", 40);
        check("postrst_pkt_count", 128'(pkt_count), 128'(1));

        // sources 0 and 2 continuously valid
        for (int p = 6; p < 9; p++) begin
            send_pkt(0, p, 1, -1, 0);
            send_pkt(2, p, 1, -1, 0);
        end
        for (int i = 0; i < 6; i++) expect_pkt(ord6_src[i], ord6_pkt[i], 1);
        wait_drain("pair_drain", 40);
        check("pair_pkt_count", 128'(pkt_count), 128'(7));

        // source 0 raised mid-way through a source-2 packet waits for its tlast
        send_pkt(2, 9, 3, -1, 0);
        send_pkt(0, 9, 1, 0, 1);
        expect_pkt(2, 9, 3);
        expect_pkt(0, 9, 1);
        step(2);
        check("nopreempt_locked", 128'(locked), 128'(1));
        check("nopreempt_cur_grant", 128'(cur_grant), 128'(2));
        check("nopreempt_in_tready", 128'(in_tready), 128'(4'b0100));
        wait_drain("nopreempt_drain", 40);
        check("nopreempt_pkt_count", 128'(pkt_count), 128'(9));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
